// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector 0 .. 2**N_IN-1 onto a
// combinational DUT, waits SETTLE cycles per vector, samples dut_y, and
// compares the captured table against a latched expected table.
//
// Optional feature: define STOP_ON_FAIL_EN to end the sweep at the first
// mismatching vector instead of covering the full table.
module truth_table_sweeper #(
  parameter int N_IN   = 4,  // 3 or 4 inputs swept
  parameter int SETTLE = 1   // 1..15 settle cycles per vector
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [3:0]  dut_in,
  input  logic        dut_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] result,
  output logic [3:0]  fail_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'((1 << N_IN) - 1);
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] result_q, result_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_idx_q, fail_idx_d;
  logic        failed_q, failed_d;
  logic        mismatch;
  logic        stop;

  // Current sample disagrees with the latched expected bit.
  assign mismatch = (dut_y != exp_q[idx_q]);

`ifdef STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  // Next-state and datapath update for the sweep sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    result_d   = result_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    failed_d   = failed_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d      = expected;
          result_d   = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          failed_d   = 1'b0;
          idx_d      = '0;
          cnt_d      = CNT_LOAD;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        result_d[idx_q] = dut_y;
        // Only the lowest mismatching index is kept.
        if (mismatch && !failed_q) begin
          failed_d   = 1'b1;
          fail_idx_d = idx_q;
        end
        if ((idx_q == LAST_IDX) || stop) begin
          pass_d  = !(failed_q || mismatch);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      result_q   <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      failed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      failed_q   <= failed_d;
    end
  end

  // The vector index register doubles as the registered DUT stimulus.
  assign dut_in   = idx_q;
  assign busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign result   = result_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper (N_IN=4, SETTLE=2). A behavioural
// DUT (a 16-entry lookup table) answers dut_in; each accepted sweep pushes the
// predicted verdict and done cycle, and a monitor pops on every done pulse.
module tb_truth_table_sweeper;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << N_IN;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [3:0]  fidx;
    logic [15:0] res;
    logic [3:0]  last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] expected;
  logic [3:0]  dut_in;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [3:0]  fail_idx;

  logic [15:0] func;
  int          cyc;
  int          tests;
  int          fails;
  exp_t        q[$];

  truth_table_sweeper #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .expected(expected),
    .dut_in  (dut_in),
    .dut_y   (dut_y),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .result  (result),
    .fail_idx(fail_idx)
  );

  assign dut_y = func[dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the table vector by vector, one SETTLE+1 slot each.
  function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int acc);
    exp_t r;
    bit   bad;
    r.res  = '0;
    r.fidx = '0;
    r.last = 4'(NVEC - 1);
    bad    = 0;
    for (int i = 0; i < NVEC; i++) begin
      r.res[i] = f[i];
      if (f[i] != e[i] && !bad) begin
        bad    = 1;
        r.fidx = 4'(i);
`ifdef STOP_ON_FAIL_EN
        r.last = 4'(i);
        break;
`endif
      end
    end
    r.pass = !bad;
    r.cyc  = acc + (int'(r.last) + 1) * (SETTLE + 1);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1, expected no done (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("pass", pass, e.pass);
          check("fail_idx", fail_idx, e.fidx);
          check("result", result, e.res);
          check("dut_in_last", dut_in, e.last);
          check("busy_in_done", busy, 0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dut_in"}, dut_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_fail_idx"}, fail_idx, 0);
  endtask

  // perturb: re-pulse start and flip expected mid-sweep; abort: reset at that cycle.
  task automatic sweep(input logic [15:0] f, input logic [15:0] e, input bit perturb,
                       input int abort);
    int acc;
    @(negedge clk);
    func     = f;
    expected = e;
    start    = 1'b1;
    acc      = cyc + 1;
    q.push_back(model(f, e, acc));
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_result_clr", result, 0);
    check("accept_pass_clr", pass, 0);
    check("accept_fail_idx_clr", fail_idx, 0);
    if (abort > 0) begin
      while (cyc < acc + abort) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      check_all_zero("abort");
      repeat (NVEC * (SETTLE + 1) + 4) @(negedge clk);
      return;
    end
    if (perturb) begin
      while (cyc < acc + 5) @(negedge clk);
      start    = 1'b1;
      expected = ~e;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done seen, expected done pulse (cycle %0d)", cyc);
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] f;
    logic [15:0] m;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    func     = '0;
    expected = '0;
    start    = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // dut_y stuck at 0, only vector 8 expects 1.
    sweep(16'h0000, 16'h0100, 0, 0);
    // Clean pass with a random function.
    f = 16'($urandom);
    sweep(f, f, 0, 0);
    // Perturbed sweeps must match the unperturbed prediction.
    f = 16'($urandom);
    sweep(f, f, 1, 0);
    f = 16'($urandom);
    sweep(f, f ^ 16'h0410, 1, 0);

    for (int n = 0; n < 12; n++) begin
      f = 16'($urandom);
      m = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) m = m | 16'($urandom);
      sweep(f, f ^ m, $urandom_range(0, 1) == 1, 0);
    end

    // Reset partway through, then a full sweep afterwards.
    f = 16'($urandom);
    sweep(f, f ^ 16'h8000, 0, 7);
    f = 16'($urandom);
    sweep(f, f ^ 16'h0020, 0, 0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
